// File: rtl/complex_multiplier_nch.sv
// Multi-lane complex multiply (a*b or a*conj(b)); latency STAGES cycles, whole pipe stalls when output is held.
// Define CMULT_SATURATE_EN to clamp out-of-range results instead of wrapping.
module complex_multiplier_nch #(
  parameter int OPERAND_WIDTH_A   = 16,
  parameter int OPERAND_WIDTH_B   = 16,
  parameter int OPERAND_WIDTH_OUT = 16,
  parameter int CHANNELS          = 1,
  parameter int STAGES            = 6,
  parameter int ROUND_MODE        = 0,
  parameter int GROWTH_BITS       = 0,
  parameter int USER_WIDTH        = 1
) (
  input  logic                                     aclk,
  input  logic                                     aresetn,
  input  logic [CHANNELS*2*OPERAND_WIDTH_A-1:0]    s_axis_a_tdata,
  input  logic                                     s_axis_a_tvalid,
  output logic                                     s_axis_a_tready,
  input  logic [CHANNELS*2*OPERAND_WIDTH_B-1:0]    s_axis_b_tdata,
  input  logic                                     s_axis_b_tvalid,
  output logic                                     s_axis_b_tready,
  input  logic                                     s_axis_b_tlast,
  input  logic [USER_WIDTH-1:0]                    s_axis_b_tuser,
  input  logic                                     s_axis_b_conj,
  output logic [CHANNELS*2*OPERAND_WIDTH_OUT-1:0]  m_axis_dout_tdata,
  output logic                                     m_axis_dout_tvalid,
  input  logic                                     m_axis_dout_tready,
  output logic                                     m_axis_dout_tlast,
  output logic [USER_WIDTH-1:0]                    m_axis_dout_tuser
);
  localparam int WA         = OPERAND_WIDTH_A;
  localparam int WB         = OPERAND_WIDTH_B;
  localparam int WO         = OPERAND_WIDTH_OUT;
  localparam int PW         = WA + WB;
  localparam int FW         = PW + 1;
  localparam int TRUNC_BITS = FW - WO + GROWTH_BITS;
  localparam int RSH        = (TRUNC_BITS > 0) ? TRUNC_BITS - 1 : 0;
  localparam logic signed [FW:0] RND =
      (ROUND_MODE == 1 && TRUNC_BITS > 0) ? ((FW+1)'(1) <<< RSH) : '0;
`ifdef CMULT_SATURATE_EN
  localparam int SW         = FW + 1 - TRUNC_BITS;
`endif

  logic                  advance;
  logic                  accept;
  logic [STAGES-1:0]     vld;
  logic [STAGES-1:0]     lst;
  logic [USER_WIDTH-1:0] usr [STAGES];
  logic [1:0]            cnj;

  assign advance         = !m_axis_dout_tvalid || m_axis_dout_tready;
  assign accept          = advance && s_axis_a_tvalid && s_axis_b_tvalid;
  assign s_axis_a_tready = aresetn && advance && s_axis_b_tvalid;
  assign s_axis_b_tready = aresetn && advance && s_axis_a_tvalid;

  assign m_axis_dout_tvalid = vld[STAGES-1];
  assign m_axis_dout_tlast  = lst[STAGES-1];
  assign m_axis_dout_tuser  = usr[STAGES-1];

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      vld <= '0;
      lst <= '0;
      cnj <= '0;
      for (int i = 0; i < STAGES; i++) usr[i] <= '0;
    end else if (advance) begin
      vld    <= {vld[STAGES-2:0], accept};
      lst    <= {lst[STAGES-2:0], s_axis_b_tlast};
      cnj    <= {cnj[0], s_axis_b_conj};
      usr[0] <= s_axis_b_tuser;
      for (int i = 1; i < STAGES; i++) usr[i] <= usr[i-1];
    end
  end

  // Round, arithmetic shift, then wrap or clamp to the output width.
  function automatic logic [WO-1:0] quant(input logic signed [FW-1:0] x);
    logic signed [FW:0] r;
`ifdef CMULT_SATURATE_EN
    logic signed [SW-1:0] v;
`endif
    r = (FW+1)'(x) + RND;
`ifdef CMULT_SATURATE_EN
    v = SW'(r >>> TRUNC_BITS);
    if (v[SW-1:WO-1] == {(SW-WO+1){1'b0}} || v[SW-1:WO-1] == {(SW-WO+1){1'b1}})
      return v[WO-1:0];
    else if (v[SW-1])
      return {1'b1, {(WO-1){1'b0}}};
    else
      return {1'b0, {(WO-1){1'b1}}};
`else
    return WO'(r >>> TRUNC_BITS);
`endif
  endfunction

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    logic signed [WA-1:0] a_re, a_im;
    logic signed [WB-1:0] b_re, b_im;
    logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [FW-1:0] re_full, im_full;
    logic signed [WO-1:0] res_re [STAGES-3];
    logic signed [WO-1:0] res_im [STAGES-3];

    always_ff @(posedge aclk) begin
      if (!aresetn) begin
        a_re    <= '0;
        a_im    <= '0;
        b_re    <= '0;
        b_im    <= '0;
        p_rr    <= '0;
        p_ii    <= '0;
        p_ri    <= '0;
        p_ir    <= '0;
        re_full <= '0;
        im_full <= '0;
        for (int i = 0; i < STAGES-3; i++) begin
          res_re[i] <= '0;
          res_im[i] <= '0;
        end
      end else if (advance) begin
        a_re <= s_axis_a_tdata[2*WA*k +: WA];
        a_im <= s_axis_a_tdata[2*WA*k+WA +: WA];
        b_re <= s_axis_b_tdata[2*WB*k +: WB];
        b_im <= s_axis_b_tdata[2*WB*k+WB +: WB];
        p_rr <= PW'(a_re) * PW'(b_re);
        p_ii <= PW'(a_im) * PW'(b_im);
        p_ri <= PW'(a_re) * PW'(b_im);
        p_ir <= PW'(a_im) * PW'(b_re);
        // Conjugation flips the sign of every b_im term; done as add/sub to avoid negating -2^(WB-1).
        if (cnj[1]) begin
          re_full <= FW'(p_rr) + FW'(p_ii);
          im_full <= FW'(p_ir) - FW'(p_ri);
        end else begin
          re_full <= FW'(p_rr) - FW'(p_ii);
          im_full <= FW'(p_ir) + FW'(p_ri);
        end
        res_re[0] <= quant(re_full);
        res_im[0] <= quant(im_full);
        for (int i = 1; i < STAGES-3; i++) begin
          res_re[i] <= res_re[i-1];
          res_im[i] <= res_im[i-1];
        end
      end
    end

    assign m_axis_dout_tdata[2*WO*k +: WO]    = res_re[STAGES-4];
    assign m_axis_dout_tdata[2*WO*k+WO +: WO] = res_im[STAGES-4];
  end

endmodule

// File: tb/tb_complex_multiplier_nch.sv
// Bench: three single-lane variants (default / round / growth -1) share stimulus, plus a 4-lane variant.
module tb_complex_multiplier_nch;
  localparam int CH [4] = '{1, 1, 1, 4};
  localparam int RM [4] = '{0, 1, 0, 1};
  localparam int GB [4] = '{0, 0, -1, 0};
  localparam int ST [4] = '{6, 6, 6, 7};
`ifdef CMULT_SATURATE_EN
  localparam logic [31:0] P025_I2 = 32'h7FFF_0000;
`else
  localparam logic [31:0] P025_I2 = 32'h8000_0000;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic arst_n;

  logic [31:0]  s_a, s_b;
  logic         s_av, s_bv, s_l, s_c, s_rdy;
  logic [3:0]   s_u;
  logic [127:0] m_a, m_b;
  logic         m_av, m_bv, m_l, m_c, m_rdy;
  logic [3:0]   m_u;

  logic         a_rdy [4];
  logic         b_rdy [4];
  logic         o_vld [4];
  logic         o_lst [4];
  logic [3:0]   o_usr [4];
  logic [31:0]  d0, d1, d2;
  logic [127:0] d3;

  complex_multiplier_nch #(.USER_WIDTH(4)) u0 (
    .aclk(clk), .aresetn(arst_n),
    .s_axis_a_tdata(s_a), .s_axis_a_tvalid(s_av), .s_axis_a_tready(a_rdy[0]),
    .s_axis_b_tdata(s_b), .s_axis_b_tvalid(s_bv), .s_axis_b_tready(b_rdy[0]),
    .s_axis_b_tlast(s_l), .s_axis_b_tuser(s_u), .s_axis_b_conj(s_c),
    .m_axis_dout_tdata(d0), .m_axis_dout_tvalid(o_vld[0]), .m_axis_dout_tready(s_rdy),
    .m_axis_dout_tlast(o_lst[0]), .m_axis_dout_tuser(o_usr[0]));

  complex_multiplier_nch #(.ROUND_MODE(1), .USER_WIDTH(4)) u1 (
    .aclk(clk), .aresetn(arst_n),
    .s_axis_a_tdata(s_a), .s_axis_a_tvalid(s_av), .s_axis_a_tready(a_rdy[1]),
    .s_axis_b_tdata(s_b), .s_axis_b_tvalid(s_bv), .s_axis_b_tready(b_rdy[1]),
    .s_axis_b_tlast(s_l), .s_axis_b_tuser(s_u), .s_axis_b_conj(s_c),
    .m_axis_dout_tdata(d1), .m_axis_dout_tvalid(o_vld[1]), .m_axis_dout_tready(s_rdy),
    .m_axis_dout_tlast(o_lst[1]), .m_axis_dout_tuser(o_usr[1]));

  complex_multiplier_nch #(.GROWTH_BITS(-1), .USER_WIDTH(4)) u2 (
    .aclk(clk), .aresetn(arst_n),
    .s_axis_a_tdata(s_a), .s_axis_a_tvalid(s_av), .s_axis_a_tready(a_rdy[2]),
    .s_axis_b_tdata(s_b), .s_axis_b_tvalid(s_bv), .s_axis_b_tready(b_rdy[2]),
    .s_axis_b_tlast(s_l), .s_axis_b_tuser(s_u), .s_axis_b_conj(s_c),
    .m_axis_dout_tdata(d2), .m_axis_dout_tvalid(o_vld[2]), .m_axis_dout_tready(s_rdy),
    .m_axis_dout_tlast(o_lst[2]), .m_axis_dout_tuser(o_usr[2]));

  complex_multiplier_nch #(.CHANNELS(4), .STAGES(7), .ROUND_MODE(1), .USER_WIDTH(4)) u3 (
    .aclk(clk), .aresetn(arst_n),
    .s_axis_a_tdata(m_a), .s_axis_a_tvalid(m_av), .s_axis_a_tready(a_rdy[3]),
    .s_axis_b_tdata(m_b), .s_axis_b_tvalid(m_bv), .s_axis_b_tready(b_rdy[3]),
    .s_axis_b_tlast(m_l), .s_axis_b_tuser(m_u), .s_axis_b_conj(m_c),
    .m_axis_dout_tdata(d3), .m_axis_dout_tvalid(o_vld[3]), .m_axis_dout_tready(m_rdy),
    .m_axis_dout_tlast(o_lst[3]), .m_axis_dout_tuser(o_usr[3]));

  typedef struct {
    int           inst;
    int           age;
    logic [127:0] dat;
    logic         lst;
    logic [3:0]   usr;
  } exp_t;

  exp_t scb[$];
  int   acc_cnt [4];
  bit   rst_edge;
  int   checks;
  int   errors;

  task automatic check(input string name, input int i, input logic [127:0] act, input logic [127:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s inst%0d got %h want %h at %0t", name, i, act, want, $time);
    end
  endtask

  // Scale a full-precision component to 16 bits: optional half-up rounding, shift, wrap or clamp.
  function automatic logic [15:0] q16(input longint full, input int rm, input int gb);
    int     t;
    longint v;
    t = 17 + gb;
    v = full;
    if (rm == 1 && t > 0) v = v + (longint'(1) <<< (t - 1));
    v = v >>> t;
`ifdef CMULT_SATURATE_EN
    if (v > 32767) v = 32767;
    else if (v < -32768) v = -32768;
`endif
    return v[15:0];
  endfunction

  function automatic logic [127:0] model(input int i, input logic [127:0] a, input logic [127:0] b, input bit cj);
    logic [127:0] r;
    r = '0;
    for (int l = 0; l < CH[i]; l++) begin
      longint ar, ai, br, bi;
      ar = longint'($signed(a[32*l +: 16]));
      ai = longint'($signed(a[32*l+16 +: 16]));
      br = longint'($signed(b[32*l +: 16]));
      bi = longint'($signed(b[32*l+16 +: 16]));
      if (cj) bi = -bi;
      r[32*l +: 16]    = q16(ar*br - ai*bi, RM[i], GB[i]);
      r[32*l+16 +: 16] = q16(ar*bi + ai*br, RM[i], GB[i]);
    end
    return r;
  endfunction

  function automatic logic [127:0] odat(input int i);
    case (i)
      0:       return {96'd0, d0};
      1:       return {96'd0, d1};
      2:       return {96'd0, d2};
      default: return d3;
    endcase
  endfunction

  task automatic run_checker();
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        int           h;
        bit           ev, adv, av, bv, rd, cj, ll;
        logic [127:0] ia, ib;
        logic [3:0]   uu;
        h = -1;
        for (int j = 0; j < scb.size(); j++)
          if (h < 0 && scb[j].inst == i) h = j;
        ev = (h >= 0) && (scb[h].age == ST[i]);
        av = (i < 3) ? s_av : m_av;
        bv = (i < 3) ? s_bv : m_bv;
        rd = (i < 3) ? s_rdy : m_rdy;
        cj = (i < 3) ? s_c : m_c;
        ll = (i < 3) ? s_l : m_l;
        uu = (i < 3) ? s_u : m_u;
        ia = (i < 3) ? {96'd0, s_a} : m_a;
        ib = (i < 3) ? {96'd0, s_b} : m_b;
        check("tvalid", i, 128'(o_vld[i]), 128'(ev));
        if (ev) begin
          check("tdata", i, odat(i), scb[h].dat);
          check("tlast", i, 128'(o_lst[i]), 128'(scb[h].lst));
          check("tuser", i, 128'(o_usr[i]), 128'(scb[h].usr));
        end
        if (rst_edge) begin
          check("rst_tdata", i, odat(i), '0);
          check("rst_tlast_tuser", i, 128'({o_lst[i], o_usr[i]}), '0);
        end
        adv = !ev || rd;
        check("a_tready", i, 128'(a_rdy[i]), 128'(arst_n && adv && bv));
        check("b_tready", i, 128'(b_rdy[i]), 128'(arst_n && adv && av));
        if (!arst_n) begin
          for (int j = scb.size() - 1; j >= 0; j--)
            if (scb[j].inst == i) scb.delete(j);
        end else if (adv) begin
          if (ev) scb.delete(h);
          for (int j = 0; j < scb.size(); j++)
            if (scb[j].inst == i) scb[j].age = scb[j].age + 1;
          if (av && bv) begin
            exp_t e;
            e.inst = i;
            e.age  = 1;
            e.dat  = model(i, ia, ib, cj);
            e.lst  = ll;
            e.usr  = uu;
            scb.push_back(e);
            acc_cnt[i]++;
          end
        end
      end
      rst_edge = !arst_n;
    end
  endtask

  // Caller sits just after a rising edge with s_rdy high and the pipe free.
  task automatic send_s(input logic [31:0] a, input logic [31:0] b, input bit cj, output int lat);
    s_a = a; s_b = b; s_c = cj; s_l = 1'b1; s_u = 4'hA;
    s_av = 1'b1; s_bv = 1'b1;
    @(posedge clk); #1;
    s_av = 1'b0; s_bv = 1'b0; s_l = 1'b0; s_u = 4'h0;
    lat = 1;
    while (!o_vld[0] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat, bad, n0;
    checks = 0; errors = 0; rst_edge = 1'b0;
    for (int i = 0; i < 4; i++) acc_cnt[i] = 0;
    arst_n = 1'b0;
    s_a = '0; s_b = '0; s_l = 1'b0; s_c = 1'b0; s_u = '0; s_rdy = 1'b1;
    s_av = 1'b1; s_bv = 1'b1;
    m_a = '0; m_b = '0; m_l = 1'b0; m_c = 1'b0; m_u = '0; m_rdy = 1'b1;
    m_av = 1'b0; m_bv = 1'b0;
    fork run_checker(); join_none

    repeat (3) @(posedge clk);
    #1;
    check("reset_tready", 0, 128'(a_rdy[0]), '0);
    check("reset_tvalid", 0, 128'(o_vld[0]), '0);
    check("reset_tdata", 0, 128'(d0), '0);
    s_av = 1'b0; s_bv = 1'b0;
    arst_n = 1'b1;
    @(posedge clk); #1;

    send_s(32'h4000_4000, 32'h4000_4000, 1'b0, lat);
    check("lat_basic", 0, 128'(lat), 128'(6));
    check("basic_i0", 0, 128'(d0), 128'(32'h1000_0000));
    check("basic_i1", 1, 128'(d1), 128'(32'h1000_0000));
    check("basic_i2", 2, 128'(d2), 128'(32'h2000_0000));
    send_s(32'h4000_4000, 32'h4000_4000, 1'b1, lat);
    check("lat_conj", 0, 128'(lat), 128'(6));
    check("conj_i0", 0, 128'(d0), 128'(32'h0000_1000));
    check("conj_i1", 1, 128'(d1), 128'(32'h0000_1000));
    check("conj_i2", 2, 128'(d2), 128'(32'h0000_2000));
    send_s(32'h0000_FFFE, 32'h0000_8000, 1'b0, lat);
    check("neg2_trunc", 0, 128'(d0), 128'(32'h0000_0000));
    check("neg2_round", 1, 128'(d1), 128'(32'h0000_0001));
    check("neg2_g1", 2, 128'(d2), 128'(32'h0000_0001));
    send_s(32'h0000_0002, 32'h0000_8000, 1'b0, lat);
    check("pos2_trunc", 0, 128'(d0), 128'(32'h0000_FFFF));
    check("pos2_round", 1, 128'(d1), 128'(32'h0000_0000));
    check("pos2_g1", 2, 128'(d2), 128'(32'h0000_FFFF));
    send_s(32'h8000_8000, 32'h8000_8000, 1'b0, lat);
    check("min_i0", 0, 128'(d0), 128'(32'h4000_0000));
    check("min_i1", 1, 128'(d1), 128'(32'h4000_0000));
    check("min_g1_overflow", 2, 128'(d2), 128'(P025_I2));
    repeat (2) @(posedge clk);
    #1;

    // A lone valid must never be taken.
    s_av = 1'b1; s_bv = 1'b0; bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (a_rdy[0] || o_vld[0]) bad++;
    end
    check("lone_valid", 0, 128'(bad), '0);
    @(posedge clk); #1;
    s_av = 1'b0;

    // Reset with three beats in flight.
    for (int k = 0; k < 3; k++) begin
      s_a = 32'h0100_0200 + 32'(k); s_b = 32'h0300_0400; s_c = 1'b0;
      s_av = 1'b1; s_bv = 1'b1;
      @(posedge clk); #1;
    end
    s_av = 1'b0; s_bv = 1'b0;
    arst_n = 1'b0;
    @(posedge clk); #1;
    check("flush_tvalid", 0, 128'(o_vld[0]), '0);
    arst_n = 1'b1;
    @(posedge clk); #1;
    send_s(32'h4000_4000, 32'h4000_4000, 1'b0, lat);
    check("lat_after_reset", 0, 128'(lat), 128'(6));
    check("data_after_reset", 0, 128'(d0), 128'(32'h1000_0000));
    repeat (2) @(posedge clk);
    #1;

    // Random traffic with output stalls on every variant.
    n0 = acc_cnt[3];
    for (int cyc = 0; cyc < 3000 && acc_cnt[3] < n0 + 100; cyc++) begin
      m_a = {$urandom, $urandom, $urandom, $urandom};
      m_b = {$urandom, $urandom, $urandom, $urandom};
      m_av = ($urandom_range(0, 3) != 0); m_bv = ($urandom_range(0, 3) != 0);
      m_l = 1'($urandom); m_u = 4'($urandom); m_c = 1'($urandom);
      m_rdy = 1'($urandom);
      s_a = $urandom; s_b = $urandom;
      s_av = ($urandom_range(0, 3) != 0); s_bv = ($urandom_range(0, 3) != 0);
      s_l = 1'($urandom); s_u = 4'($urandom); s_c = 1'($urandom);
      s_rdy = 1'($urandom);
      @(posedge clk); #1;
    end
    check("random_beats", 3, 128'(acc_cnt[3] - n0 >= 100), 128'(1));
    m_av = 1'b0; m_bv = 1'b0; m_rdy = 1'b1;
    s_av = 1'b0; s_bv = 1'b0; s_rdy = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("drained", 0, 128'(scb.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
